iter_shifter: RTL and testbench

//  Parametrised multi-cycle shifter/rotator for the datapath's B-operand path.
//  - Accepts one operand, a mode and a shift amount per transaction; shifts one bit per clock.
//  - Returns the result with carry-out and zero flags through a valid/ready pair.
//  - Supersedes the fixed 16-bit single-position shifter: adds width, amount and rotate modes.

---
 rtl/iter_shifter.sv | 91 +++++++++
 tb/tb_iter_shifter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle one-bit-per-clock shifter/rotator with valid/ready handshake
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [AMT_W-1:0] W = AMT_W'(WIDTH);
    state_t           state, nxt_state;
    logic [WIDTH-1:0] d, nxt_d, step_d;
    logic [2:0]       mode, nxt_mode;
    logic [AMT_W-1:0] cnt, nxt_cnt, load;
    logic             carry, nxt_carry, err, nxt_err, step_c;
    always_comb begin
        step_d = d;
        step_c = 1'b0;
        case (mode)
            3'd1: begin step_d = {d[WIDTH-2:0], 1'b0};      step_c = d[WIDTH-1]; end
            3'd2: begin step_d = {1'b0, d[WIDTH-1:1]};      step_c = d[0];       end
            3'd3: begin step_d = {d[WIDTH-1], d[WIDTH-1:1]}; step_c = d[0];      end
            3'd4: begin step_d = {d[WIDTH-2:0], d[WIDTH-1]}; step_c = d[WIDTH-1]; end
            3'd5: begin step_d = {d[0], d[WIDTH-1:1]};      step_c = d[0];       end
            default: ;
        endcase
    end
    // shifts saturate at WIDTH steps, rotates wrap modulo WIDTH
    assign load = (in_mode inside {3'd1, 3'd2, 3'd3}) ? ((in_amt >= W) ? W : in_amt)
                : (in_mode inside {3'd4, 3'd5}) ? in_amt % W : '0;
    always_comb begin
        nxt_state = state;
        nxt_d     = d;
        nxt_mode  = mode;
        nxt_cnt   = cnt;
        nxt_carry = carry;
        nxt_err   = err;
        case (state)
            IDLE: if (in_valid) begin
                nxt_d     = in_data;
                nxt_mode  = in_mode;
                nxt_err   = in_mode > 3'd5;
                nxt_carry = 1'b0;
                nxt_cnt   = load;
                nxt_state = (load != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                nxt_d     = step_d;
                nxt_carry = step_c;
                nxt_cnt   = cnt - 1'b1;
                nxt_state = (cnt == AMT_W'(1)) ? DONE : SHIFT;
            end
            DONE: nxt_state = out_ready ? IDLE : DONE;
            default: nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            d     <= '0;
            mode  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt_state;
            d     <= nxt_d;
            mode  <= nxt_mode;
            cnt   <= nxt_cnt;
            carry <= nxt_carry;
            err   <= nxt_err;
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = d;
    assign out_carry = carry;
    assign out_zero  = d == '0;
    assign out_err   = err;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed and randomized checks of iter_shifter against an arithmetic model
module tb_iter_shifter;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] in_data = '0, out_data;
    logic [2:0]  in_mode = '0;
    logic [4:0]  in_amt = '0;
    logic        out_carry, out_zero, out_err;
    int          vectors = 0, miscompares = 0;

    iter_shifter #(.WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
        .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] d, input logic [2:0] m, input int a,
                                  output logic [15:0] r, output logic c, output logic e,
                                  output int lat);
        int n, k;
        n = (a > 16) ? 16 : a;
        k = a % 16;
        r = d; c = 1'b0; e = 1'b0; lat = 1;
        case (m)
            3'd1: begin r = (n >= 16) ? 16'h0 : d << n; if (n > 0) c = d[16-n]; lat = n + 1; end
            3'd2: begin r = d >> n; if (n > 0) c = d[n-1]; lat = n + 1; end
            3'd3: begin r = $signed(d) >>> n; if (n > 0) c = d[n-1]; lat = n + 1; end
            3'd4: begin if (k > 0) begin r = (d << k) | (d >> (16 - k)); c = r[0]; end lat = k + 1; end
            3'd5: begin if (k > 0) begin r = (d >> k) | (d << (16 - k)); c = r[15]; end lat = k + 1; end
            3'd6, 3'd7: e = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic reset_chk(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 1);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".out_data"}, 32'(out_data), 0);
        chk({tag, ".out_carry"}, 32'(out_carry), 0);
        chk({tag, ".out_zero"}, 32'(out_zero), 1);
        chk({tag, ".out_err"}, 32'(out_err), 0);
    endtask

    task automatic run(input logic [15:0] d, input logic [2:0] m, input logic [4:0] a,
                       input int stall, input bit full);
        logic [15:0] er;
        logic ec, ee;
        int el, lat;
        model(d, m, int'(a), er, ec, ee, el);
        @(negedge clk);
        chk("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = d; in_mode = m; in_amt = a; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0; in_data = 16'($urandom); in_mode = 3'($urandom); in_amt = 5'($urandom);
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("data", 32'(out_data), 32'(er));
        chk("carry", 32'(out_carry), 32'(ec));
        chk("zero", 32'(out_zero), 32'(er == 16'h0));
        chk("err", 32'(out_err), 32'(ee));
        if (stall > 0) begin
            in_valid = 1'b1;
            in_data = ~d;
            in_mode = 3'd1;
            in_amt = 5'd3;
            repeat (stall) @(negedge clk);
            chk("busy_ready", 32'(in_ready), 0);
            chk("held_valid", 32'(out_valid), 1);
            chk("held_data", 32'(out_data), 32'(er));
            chk("held_carry", 32'(out_carry), 32'(ec));
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (full) begin
            @(negedge clk);
            chk("drop_valid", 32'(out_valid), 0);
            chk("idle_ready", 32'(in_ready), 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_chk("in_reset");
        resetn = 1'b1;
        @(negedge clk);
        reset_chk("post_reset");
        run(16'h8001, 3'd1, 5'd1, 0, 1'b1);
        run(16'h8000, 3'd3, 5'd4, 0, 1'b1);
        run(16'h8000, 3'd3, 5'd16, 0, 1'b1);
        run(16'h00F1, 3'd5, 5'd4, 0, 1'b1);
        run(16'h1234, 3'd4, 5'd16, 0, 1'b1);
        run(16'h0001, 3'd2, 5'd1, 5, 1'b1);
        run(16'hABCD, 3'd6, 5'd7, 0, 1'b1);
        run(16'hF00F, 3'd1, 5'd20, 0, 1'b1);
        run(16'h7FFF, 3'd3, 5'd31, 0, 1'b1);
        // abort an LSL by 10 after five steps
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hC3A5; in_mode = 3'd1; in_amt = 5'd10;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_shift_busy", 32'(in_ready), 0);
        resetn = 1'b0;
        #1 reset_chk("mid_shift_reset");
        @(negedge clk);
        resetn = 1'b1;
        run(16'hC3A5, 3'd1, 5'd10, 0, 1'b1);
        for (int i = 0; i < 200; i++)
            run(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
